// File: rtl/adc_interleave_seq.sv
// Round-robin channel sequencer for an 8:1 registered ADC interleaving mux.
// Tags each mux output sample with valid, channel and frame markers, aligned to the mux latency.
module adc_interleave_seq #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int FRM_W  = 16
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             start,
    input  logic             stop,
    input  logic [FRM_W-1:0] num_frames,
    input  logic             sample_en,
    output logic [SEL_W-1:0] x_adc_select,
    output logic             x_adc_valid,
    output logic [SEL_W-1:0] x_adc_ch,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [FRM_W-1:0]   r_frm_cnt;
    logic [FRM_W-1:0]   r_num_frames;
    logic               r_stop_pending;
    logic               r_valid;
    logic [SEL_W-1:0]   r_ch;
    logic               r_fs;
    logic               r_fe;
    logic               r_done;

    logic               w_issue;
    logic               w_sel_last;
    logic               w_stop_req;
    logic               w_count_hit;
    logic               w_last;
    logic               w_stop_exit;

    assign w_issue     = (r_state == ST_RUN) && sample_en;
    assign w_sel_last  = (r_sel == SEL_W'(NUM_CH - 1));
    assign w_stop_req  = r_stop_pending || stop;
    assign w_count_hit = (r_num_frames != '0) && (r_frm_cnt == r_num_frames - FRM_W'(1));
    assign w_last      = w_issue && w_sel_last && (w_stop_req || w_count_hit);
    // A stop with no sample yet taken in the current frame can leave without a drain cycle.
    assign w_stop_exit = (r_state == ST_RUN) && w_stop_req && (r_sel == '0) && !w_issue;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_last)           w_state_nxt = ST_DRAIN;
                else if (w_stop_exit) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_sel          <= '0;
            r_frm_cnt      <= '0;
            r_num_frames   <= '0;
            r_stop_pending <= 1'b0;
            r_valid        <= 1'b0;
            r_ch           <= '0;
            r_fs           <= 1'b0;
            r_fe           <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            // Output stage mirrors the mux's one-cycle registered latency.
            r_valid <= w_issue;
            r_ch    <= r_sel;
            r_fs    <= w_issue && (r_sel == '0);
            r_fe    <= w_issue && w_sel_last;
            r_done  <= (r_state == ST_RUN) && (w_state_nxt != ST_RUN);

            if ((r_state == ST_IDLE) && start) begin
                r_num_frames   <= num_frames;
                r_frm_cnt      <= '0;
                r_stop_pending <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_stop_pending <= w_stop_req;
            end

            if (w_issue) begin
                r_sel <= w_sel_last ? '0 : r_sel + SEL_W'(1);
                if (w_sel_last) r_frm_cnt <= r_frm_cnt + FRM_W'(1);
            end
        end
    end

    assign x_adc_select = r_sel;
    assign x_adc_valid  = r_valid;
    assign x_adc_ch     = r_ch;
    assign frame_start  = r_fs;
    assign frame_end    = r_fe;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;

endmodule

// File: tb/tb_adc_interleave_seq.sv
// Randomized scoreboard bench for adc_interleave_seq.
// A sample-count model predicts every tagged output; a monitor compares them as they appear.
module tb_adc_interleave_seq;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int FRM_W  = 16;

    logic             clk = 1'b0;
    logic             GlobalReset;
    logic             start;
    logic             stop;
    logic [FRM_W-1:0] num_frames;
    logic             sample_en;
    logic [SEL_W-1:0] x_adc_select;
    logic             x_adc_valid;
    logic [SEL_W-1:0] x_adc_ch;
    logic             frame_start;
    logic             frame_end;
    logic             busy;
    logic             done;

    adc_interleave_seq #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .FRM_W(FRM_W)) dut (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .start        (start),
        .stop         (stop),
        .num_frames   (num_frames),
        .sample_en    (sample_en),
        .x_adc_select (x_adc_select),
        .x_adc_valid  (x_adc_valid),
        .x_adc_ch     (x_adc_ch),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        int cyc;
        int ch;
        bit fs;
        bit fe;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    // Reference model: a run is a stream of samples numbered from 0.
    typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;
    mode_t m_mode  = M_IDLE;
    int    m_n     = 0;
    int    m_nf    = 0;
    bit    m_stop  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step(input bit st, input bit sp, input bit se, input int nf);
        bit   req;
        int   ch;
        int   frame;
        exp_t e;
        @(posedge clk);
        #1;
        check("select", 32'(x_adc_select), (m_mode == M_RUN) ? 32'(m_n % NUM_CH) : 32'd0);
        check("busy", 32'(busy), 32'(m_mode != M_IDLE));
        start      = st;
        stop       = sp;
        sample_en  = se;
        num_frames = FRM_W'(nf);
        case (m_mode)
            M_IDLE: begin
                if (st) begin
                    m_mode = M_RUN;
                    m_n    = 0;
                    m_nf   = nf;
                    m_stop = 1'b0;
                end
            end
            M_DRAIN: m_mode = M_IDLE;
            M_RUN: begin
                req   = m_stop || sp;
                ch    = m_n % NUM_CH;
                frame = m_n / NUM_CH;
                if (se) begin
                    e.cyc = cyc + 1;
                    e.ch  = ch;
                    e.fs  = (ch == 0);
                    e.fe  = (ch == NUM_CH - 1);
                    exp_q.push_back(e);
                    m_n++;
                    if (ch == NUM_CH - 1 &&
                        (req || (m_nf != 0 && (frame % 65536) == m_nf - 1))) begin
                        m_mode = M_DRAIN;
                        done_q.push_back(cyc + 1);
                    end
                end else if (req && ch == 0) begin
                    m_mode = M_IDLE;
                    done_q.push_back(cyc + 1);
                end
                m_stop = req;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic finish_run(input int mode_se);
        int k = 0;
        while (m_mode != M_IDLE && k < 400) begin
            step(1'b0, 1'b0, (mode_se == 1) ? 1'b1 : (mode_se == 2 ? bit'(k % 2 == 0) : bit'($urandom_range(0, 3) != 0)), 0);
            k++;
        end
        check("run_terminates", 32'(m_mode != M_IDLE), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {19'd0, x_adc_select, x_adc_valid, x_adc_ch, frame_start, frame_end, busy, done}, 32'd0);
    endtask

    task automatic reset_mid_cycle();
        @(posedge clk);
        #3;
        GlobalReset = 1'b0;
        #1;
        check_outputs_zero("async_reset_outputs");
        exp_q.delete();
        done_q.delete();
        m_mode    = M_IDLE;
        start     = 1'b0;
        stop      = 1'b0;
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("reset_held_outputs");
        #2;
        GlobalReset = 1'b1;
    endtask

    // Monitor: pops an expectation for every tagged sample and every done pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        if (GlobalReset) begin
            if (x_adc_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got ch=%0d with no sample expected (cycle %0d)", x_adc_ch, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_cycle", 32'(cyc), 32'(e.cyc));
                    check("ch", 32'(x_adc_ch), 32'(e.ch));
                    check("frame_start", 32'(frame_start), 32'(e.fs));
                    check("frame_end", 32'(frame_end), 32'(e.fe));
                end
            end else begin
                check("flags_without_valid", {30'd0, frame_start, frame_end}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    total++; bad++;
                    $display("FAIL missing_valid: got valid=0 expected ch=%0d at cycle %0d", exp_q[0].ch, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                total++; bad++;
                $display("FAIL missing_done: got done=0 expected 1 at cycle %0d", done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int nf;
        GlobalReset = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        sample_en   = 1'b0;
        num_frames  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        #2;
        GlobalReset = 1'b1;
        idle_cycles(2);

        // Two frames, strobe every cycle.
        step(1'b1, 1'b0, 1'b1, 2);
        finish_run(1);
        idle_cycles(2);

        // One frame, strobe on alternate cycles.
        step(1'b1, 1'b0, 1'b0, 1);
        finish_run(2);
        idle_cycles(2);

        // Continuous run, stop requested at select==3 in the second frame.
        step(1'b1, 1'b0, 1'b1, 0);
        k = 0;
        while (k < 100) begin
            if (m_n >= NUM_CH && m_n % NUM_CH == 3) begin
                step(1'b0, 1'b1, 1'b1, 0);
                break;
            end
            step(1'b0, 1'b0, 1'b1, 0);
            k++;
        end
        finish_run(1);
        idle_cycles(2);

        // Stop at a frame boundary with no strobe: immediate exit.
        step(1'b1, 1'b0, 1'b0, 0);
        idle_cycles(2);
        step(1'b0, 1'b1, 1'b0, 0);
        idle_cycles(3);

        // Reset mid-frame at select==5, then restart from channel 0.
        step(1'b1, 1'b0, 1'b1, 0);
        k = 0;
        while (m_n != 5 && k < 20) begin
            step(1'b0, 1'b0, 1'b1, 0);
            k++;
        end
        reset_mid_cycle();
        idle_cycles(3);
        step(1'b1, 1'b0, 1'b1, 1);
        finish_run(1);
        idle_cycles(2);

        // start+stop together in IDLE, then a stray start during the run.
        step(1'b1, 1'b1, 1'b1, 1);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 1'b1, 5);
        finish_run(1);
        idle_cycles(2);

        // Randomized runs.
        for (int r = 0; r < 30; r++) begin
            nf = $urandom_range(0, 3);
            step(1'b1, bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), nf);
            k = 0;
            while (m_mode != M_IDLE && k < 400) begin
                step(bit'($urandom_range(0, 9) == 0),
                     bit'($urandom_range(0, 24) == 0) || (k > 60),
                     bit'($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 7)));
                k++;
            end
            check("random_run_terminates", 32'(m_mode != M_IDLE), 32'd0);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                step(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
        end

        idle_cycles(3);
        check("pending_samples", 32'(exp_q.size()), 32'd0);
        check("pending_done", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_interleave_seq.md
Name: adc_interleave_seq

Overview:
- Sequencer directly upstream of the 8-channel x_adc interleaving mux (1-cycle registered latency).
- Drives the mux `x_adc_select` round-robin, one channel per conversion strobe.
- Emits valid, channel tag and frame markers aligned to the mux's registered `x_adc` output, so downstream logic can qualify each interleaved sample.
- Supports a fixed frame count or continuous run, with graceful stop at a frame boundary.

Parameters:
- NUM_CH, 8, channels per frame (2..8); select wraps NUM_CH-1 -> 0.
- SEL_W, 3, width of select/channel tag.
- FRM_W, 16, width of frame-count request and counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- GlobalReset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run when idle.
- stop  in  1  pulse; requests end of run at the next frame boundary.
- num_frames  in  FRM_W  frames per run, sampled on accepted start; 0 = continuous.
- sample_en  in  1  ADC conversion strobe; one sample issued per high cycle while running.
- x_adc_select  out  SEL_W  channel select to the mux.
- x_adc_valid  out  1  mux output this cycle is a valid issued sample.
- x_adc_ch  out  SEL_W  channel of the sample on the mux output.
- frame_start  out  1  with x_adc_valid, x_adc_ch==0.
- frame_end  out  1  with x_adc_valid, x_adc_ch==NUM_CH-1.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when a run finishes.

Behaviour:
- Reset (GlobalReset=0, async): state IDLE; all outputs 0, including x_adc_select; frame counter 0; stop_pending 0. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - x_adc_select held at 0; stop ignored.
  - start=1 -> RUN next cycle; latch num_frames; clear frame counter and stop_pending.
  - start and stop in the same cycle: start accepted, stop discarded.
- RUN:
  - issue = sample_en. On issue, x_adc_select advances by 1, wrapping NUM_CH-1 -> 0. With sample_en=0, select holds.
  - Frame counter increments on issue at channel NUM_CH-1, wrapping at 2^FRM_W.
  - stop=1 sets stop_pending; start is ignored.
  - Last sample = issue at channel NUM_CH-1 AND (stop_pending, or stop this cycle, or (num_frames!=0 and counter==num_frames-1)). On last sample -> DRAIN; select wraps to 0.
  - stop_pending with select==0 and no issue this cycle (no partial frame) -> IDLE next cycle, with a one-cycle done pulse in that first IDLE cycle.
- DRAIN: exactly 1 cycle. It presents the final sample's valid/frame_end; done=1 in this cycle; then IDLE.
- Output alignment (registered, 1 cycle, matching mux latency):
  - x_adc_valid(t+1) = issue(t).
  - x_adc_ch(t+1) = x_adc_select(t).
  - frame_start(t+1) = issue(t) and select(t)==0.
  - frame_end(t+1) = issue(t) and select(t)==NUM_CH-1.
  - Flags are 0 whenever x_adc_valid=0.
- Partial frames never occur: stop always completes the current frame.
- busy = (state!=IDLE).

Test Plan:
- Reset then start, num_frames=2, sample_en=1 continuously:
  - select 0..7,0..7 on consecutive cycles; x_adc_valid high 16 cycles, starting 1 cycle after the first select.
  - x_adc_ch = previous-cycle select; frame_start at ch0 (×2); frame_end at ch7 (×2).
  - done=1 coincides with the second frame_end; busy falls the next cycle; select returns to 0.
- num_frames=1, sample_en toggling 1,0,1,0…: select advances only after strobe cycles; valid pulses exactly 1 cycle after each strobe; 8 valids total, then done.
- num_frames=0 (continuous), stop pulsed when select==3: sampling continues through ch7; done with that frame_end; no further valid.
- stop while select==0 with sample_en=0 in RUN: IDLE next cycle with done=1 that cycle; no valid issued after stop.
- GlobalReset asserted mid-frame (select==5): all outputs 0 asynchronously; no done. After release, start is required; run restarts at ch0.
- start+stop same cycle in IDLE: run starts normally. A start pulse during RUN is ignored; frame count is unchanged.
